// File: rtl/ram_pkg.sv
// Shared definitions for the 16x8 program/data memory and its pushbutton debouncer.
package ram_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    WRITE,
    HELD,
    RELEASE_WAIT
  } db_state_t;
endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces the program-mode pushbutton; emits one commit per press.
module btn_debounce
  import ram_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic clr,
  input  logic enable,
  input  logic btn,
  output logic commit,
  output logic busy
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_reg;
  logic             btn_s;
  db_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;

  assign btn_s   = sync_reg[1];
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (clr) begin
      sync_reg  <= '0;
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], btn};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (enable && btn_s) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = WRITE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      WRITE: begin
        state_next = HELD;
        cnt_next   = '0;
      end
      HELD: begin
        cnt_next = '0;
        if (!btn_s) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // Leaving program mode aborts any press in flight.
    if (!enable && state_reg != IDLE) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  assign commit = (state_reg == WRITE);
  assign busy   = (state_reg != IDLE);
endmodule

// File: rtl/ram_16x8_prog.sv
// 16x8 CPU program/data memory: bus read/write in run mode, DIP-switch load in program mode.
module ram_16x8_prog
  import ram_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              prog_en,
  input  logic              ram_in_en,
  input  logic              ram_out_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_btn,
  output logic [DATA_W-1:0] bus_out,
  output logic              prog_busy,
  output logic              prog_ack
);
  localparam int DEPTH = 1 << ADDR_W;

  // Contents survive clr; the FPGA configures them to zero at power-up.
  logic [DATA_W-1:0] mem_reg [DEPTH] = '{default: '0};
  logic              commit;
  logic              prog_we, run_we;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .clr   (clr),
    .enable(prog_en),
    .btn   (prog_btn),
    .commit(commit),
    .busy  (prog_busy)
  );

  assign prog_ack = commit;
  assign prog_we  = commit && prog_en && !clr;
  assign run_we   = ram_in_en && !prog_en;

  always_ff @(posedge clk) begin
    if (prog_we)
      mem_reg[addr] <= prog_data;
    else if (run_we)
      mem_reg[addr] <= bus_in;
  end

  assign bus_out = ram_out_en ? mem_reg[addr] : '0;
endmodule

// File: tb/tb_ram_16x8_prog.sv
// Directed bench for ram_16x8_prog with a short debounce window.
module tb_ram_16x8_prog;
  logic       clk, clr, prog_en, ram_in_en, ram_out_en, prog_btn;
  logic [3:0] addr;
  logic [7:0] bus_in, prog_data, bus_out;
  logic       prog_busy, prog_ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       we;
    logic       oe;
    logic [3:0] a;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [16];

  ram_16x8_prog #(.DATA_W(8), .ADDR_W(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .clr(clr), .prog_en(prog_en), .ram_in_en(ram_in_en),
    .ram_out_en(ram_out_en), .addr(addr), .bus_in(bus_in),
    .prog_data(prog_data), .prog_btn(prog_btn), .bus_out(bus_out),
    .prog_busy(prog_busy), .prog_ack(prog_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [7:0] exp);
    addr = a;
    ram_out_en = 1'b1;
    #1;
    chk(name, {24'd0, bus_out}, {24'd0, exp});
    ram_out_en = 1'b0;
  endtask

  int acks, first_ack, gone;
  logic busy_mid;
  logic [9:0] pat;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'h3, 8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 4'h3, 8'h00, 8'hA5};
    vecs[2]  = '{1'b0, 1'b0, 4'h3, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 4'h2, 8'h11, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 4'h2, 8'h22, 8'h11};
    vecs[5]  = '{1'b0, 1'b1, 4'h2, 8'h00, 8'h22};
    vecs[6]  = '{1'b1, 1'b0, 4'h0, 8'h5A, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 4'hF, 8'hC3, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 4'h8, 8'h44, 8'h00};
    vecs[9]  = '{1'b1, 1'b0, 4'h9, 8'h99, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 4'hA, 8'hAA, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 4'h0, 8'h00, 8'h5A};
    vecs[12] = '{1'b0, 1'b1, 4'hF, 8'h00, 8'hC3};
    vecs[13] = '{1'b0, 1'b1, 4'h8, 8'h00, 8'h44};
    vecs[14] = '{1'b0, 1'b1, 4'hA, 8'h00, 8'hAA};
    vecs[15] = '{1'b0, 1'b1, 4'h3, 8'h00, 8'hA5};

    clr = 1'b1; prog_en = 1'b0; ram_in_en = 1'b0; ram_out_en = 1'b0;
    prog_btn = 1'b0; addr = '0; bus_in = '0; prog_data = '0;
    cyc(); cyc();
    clr = 1'b0;
    #1;
    chk("reset_busy", {31'd0, prog_busy}, 32'd0);
    chk("reset_ack", {31'd0, prog_ack}, 32'd0);
    chk("reset_bus_out", {24'd0, bus_out}, 32'd0);

    // Run-mode table: read is checked before the edge, so a collision shows the old word.
    for (int i = 0; i < 16; i++) begin
      ram_in_en  = vecs[i].we;
      ram_out_en = vecs[i].oe;
      addr       = vecs[i].a;
      bus_in     = vecs[i].din;
      #1;
      chk($sformatf("vec%0d", i), {24'd0, bus_out}, {24'd0, vecs[i].exp});
      cyc();
    end
    ram_in_en = 1'b0; ram_out_en = 1'b0;

    // Clean press held 20 cycles.
    prog_en = 1'b1; addr = 4'hF; prog_data = 8'h3C;
    acks = 0; first_ack = -1;
    prog_btn = 1'b1;
    for (int e = 0; e < 20; e++) begin
      cyc();
      if (prog_ack) begin acks++; if (first_ack < 0) first_ack = e; end
    end
    prog_btn = 1'b0;
    busy_mid = 1'b0; gone = -1;
    for (int e = 0; e < 12; e++) begin
      cyc();
      if (prog_ack) acks++;
      if (e == 2) busy_mid = prog_busy;
      if (!prog_busy && gone < 0) gone = e;
    end
    chk("clean_ack_count", acks, 1);
    chk("clean_ack_edge", first_ack, 6);
    chk("clean_busy_after_release", {31'd0, busy_mid}, 32'd1);
    chk("clean_busy_released", {31'd0, (gone >= 3 && gone <= 8)}, 32'd1);
    prog_en = 1'b0;
    rd("clean_mem_F", 4'hF, 8'h3C);

    // Bouncing press: glitches never last 4 synchronised cycles, then steady.
    prog_en = 1'b1; addr = 4'h7; prog_data = 8'h96;
    pat = 10'b1101001101;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      prog_btn = pat[i];
      cyc();
      if (prog_ack) acks++;
    end
    chk("bounce_no_early_ack", acks, 0);
    prog_btn = 1'b1;
    for (int i = 0; i < 15; i++) begin cyc(); if (prog_ack) acks++; end
    prog_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin cyc(); if (prog_ack) acks++; end
    chk("bounce_ack_count", acks, 1);
    rd("bounce_mem_7", 4'h7, 8'h96);

    // Press of 3 cycles is too short.
    addr = 4'h8; prog_data = 8'h77; acks = 0;
    prog_btn = 1'b1;
    for (int i = 0; i < 3; i++) begin cyc(); if (prog_ack) acks++; end
    prog_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin cyc(); if (prog_ack) acks++; end
    chk("short_ack_count", acks, 0);
    rd("short_mem_8", 4'h8, 8'h44);

    // Run-mode write ignored in program mode.
    addr = 4'h3; bus_in = 8'hFF; ram_in_en = 1'b1;
    cyc(); cyc();
    ram_in_en = 1'b0;
    rd("gated_mem_3", 4'h3, 8'hA5);

    // prog_en dropped during PRESS_WAIT.
    addr = 4'h9; prog_data = 8'h01; acks = 0;
    prog_btn = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("drop_busy_before", {31'd0, prog_busy}, 32'd1);
    prog_en = 1'b0;
    for (int i = 0; i < 10; i++) begin cyc(); if (prog_ack) acks++; end
    chk("drop_busy_after", {31'd0, prog_busy}, 32'd0);
    chk("drop_ack_count", acks, 0);
    prog_btn = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    rd("drop_mem_9", 4'h9, 8'h99);

    // clr during PRESS_WAIT.
    prog_en = 1'b1; addr = 4'hA; prog_data = 8'h0B;
    prog_btn = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("clr_pw_busy_before", {31'd0, prog_busy}, 32'd1);
    clr = 1'b1; prog_btn = 1'b0;
    cyc();
    clr = 1'b0;
    chk("clr_pw_busy_after", {31'd0, prog_busy}, 32'd0);
    for (int i = 0; i < 12; i++) cyc();

    // clr on the WRITE edge suppresses the write.
    first_ack = -1;
    prog_btn = 1'b1;
    for (int e = 0; e < 7; e++) begin
      cyc();
      if (prog_ack && first_ack < 0) first_ack = e;
    end
    chk("clr_wr_ack_edge", first_ack, 6);
    clr = 1'b1; prog_btn = 1'b0;
    cyc();
    clr = 1'b0;
    chk("clr_wr_ack_after", {31'd0, prog_ack}, 32'd0);
    chk("clr_wr_busy_after", {31'd0, prog_busy}, 32'd0);
    acks = 0;
    for (int i = 0; i < 12; i++) begin cyc(); if (prog_ack) acks++; end
    chk("clr_wr_no_ack", acks, 0);
    rd("clr_wr_mem_A", 4'hA, 8'hAA);
    rd("clr_keep_mem_F", 4'hF, 8'h3C);
    rd("clr_keep_mem_3", 4'h3, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_16x8_prog.md
# ram_16x8_prog

Program/data memory for the 8-bit CPU: 16 words × 8 bits, addressed by the 4-bit memory-address register output and sitting directly downstream of it. In run mode it is read onto and written from the shared 8-bit bus under control-word enables. In program mode it loads the word on the 8 DIP switches into the addressed location on a debounced press of a pushbutton.

## Interface
- `DATA_W`, 8, word width
- `ADDR_W`, 4, address width (depth = 2^ADDR_W = 16)
- `DEBOUNCE_CYCLES`, 50000, consecutive stable samples required (1 ms at 50 MHz); minimum 1
- `clk`  in  1  system clock, all state on rising edge
- `clr`  in  1  reset, synchronous, active-high
- `prog_en`  in  1  program mode, active-high
- `ram_in_en`  in  1  run-mode write strobe (bus → RAM), active-high
- `ram_out_en`  in  1  run-mode read strobe (RAM → bus), active-high
- `addr`  in  ADDR_W  address from the MAR (switch value in program mode, register value otherwise)
- `bus_in`  in  DATA_W  shared bus value
- `prog_data`  in  DATA_W  8-position DIP switch word
- `prog_btn`  in  1  raw, asynchronous, bouncing write pushbutton, active-high
- `bus_out`  out  DATA_W  RAM drive onto the bus mux; 0 when not enabled
- `prog_busy`  out  1  high whenever the debounce FSM is not in IDLE
- `prog_ack`  out  1  one-cycle pulse on the cycle a program-mode write commits

## Operation
- Array: 16 × DATA_W registers. `clr` does NOT modify contents; the FPGA power-up value is all zeros.
- Read: `bus_out = ram_out_en ? mem[addr] : 0`. Combinational, any mode.
- Run-mode write: when `ram_in_en && !prog_en`, `mem[addr] <= bus_in` at the clock edge.
- When `ram_in_en && ram_out_en` are both asserted, `bus_out` shows the old word during that cycle. The new word is visible from the next cycle.
- `ram_in_en` is ignored while `prog_en` is high.
- Button path: a 2-flop synchroniser produces `btn_s`. A saturating counter `cnt` has width `$clog2(DEBOUNCE_CYCLES+1)`.
- FSM states and transitions:
  - IDLE: `cnt=0`. If `prog_en && btn_s`, go to PRESS_WAIT.
  - PRESS_WAIT: if `btn_s`, increment `cnt`. When `cnt == DEBOUNCE_CYCLES-1` with `btn_s` high, go to WRITE. If `btn_s` is low, return to IDLE and clear `cnt`.
  - WRITE: one cycle. `mem[addr] <= prog_data`, `prog_ack=1`, go to HELD.
  - HELD: wait for `!btn_s`, then go to RELEASE_WAIT with `cnt=0`.
  - RELEASE_WAIT: count consecutive `!btn_s`. At `DEBOUNCE_CYCLES-1`, go to IDLE. If `btn_s` goes high, return to HELD. No write occurs here.
- `prog_en` low in any non-IDLE state: go to IDLE on the next edge. No write, no ack.
- A single press therefore yields exactly one write, regardless of bounce or hold time.

## Timing
- Reset values: FSM in IDLE, `cnt=0`, synchroniser flops 0, `prog_busy=0`, `prog_ack=0`. `bus_out` is 0 unless `ram_out_en` is high.
- `clr` mid-sequence: state returns to IDLE on that edge. A WRITE coinciding with `clr` is suppressed.
- Press latency: `prog_btn` is first sampled high at edge 0.
  - `btn_s` rises at edge 2.
  - WRITE is entered at edge `2+DEBOUNCE_CYCLES`.
  - Memory is updated and the `prog_ack` pulse ends at edge `3+DEBOUNCE_CYCLES`.
- `prog_ack` is registered state decode: high only while in WRITE.
- `addr` and `prog_data` are sampled at the WRITE edge.
- Run-mode write latency: 1 edge.
- Read latency: 0 (combinational).

## Structure
- Shared package `ram_pkg`:
  - `DATA_W`, `ADDR_W` defaults
  - the FSM state enum: IDLE, PRESS_WAIT, WRITE, HELD, RELEASE_WAIT
- Sub-module `btn_debounce`: synchroniser, counter and FSM. It takes `clk`, `clr`, `enable`, `btn` and outputs `commit`, `busy`.
- The top level holds the array, the read mux and write arbitration.

## Test plan
- Reset, then run-mode write: `clr` for 2 cycles; `addr=4'h3`, `bus_in=8'hA5`, `ram_in_en=1` for 1 cycle → next cycle with `ram_out_en=1` gives `bus_out=8'hA5`; with `ram_out_en=0`, `bus_out=8'h00`.
- Clean press: `DEBOUNCE_CYCLES=4`, `prog_en=1`, `addr=4'hF`, `prog_data=8'h3C`, button held for 20 cycles → exactly one `prog_ack` pulse, at edge 6 after the first sample; `mem[F]=8'h3C`; `prog_busy` returns low 4 cycles after the synchronised release.
- Bounce: `DEBOUNCE_CYCLES=4`, button toggles with 1–3 cycle glitches for 10 cycles, then steady → exactly one write. A press shorter than 4 synchronised cycles → no write and no ack.
- Mode gating: `prog_en=1` with `ram_in_en=1` and `bus_in=8'hFF` → memory unchanged. `prog_en` dropped during PRESS_WAIT → IDLE, no write.
- Reset mid-operation: `clr` asserted in PRESS_WAIT and again on the WRITE cycle → no write, FSM in IDLE, previously written contents preserved.
- Read/write collision: `ram_in_en=ram_out_en=1`, `addr=4'h2`, old value `8'h11`, `bus_in=8'h22` → `bus_out=8'h11` that cycle, `8'h22` the next cycle.
